// File: rtl/div_mon_pkg.sv
// Shared types and default ratio constants for the M/N divider output monitor.
// Defaults match the fractional divider configured for 87 clk_in cycles per 10 periods.
package div_mon_pkg;

  localparam int unsigned CntW = 8;
  localparam int unsigned IdxW = 5;

  localparam int unsigned MnDefault       = 87;
  localparam int unsigned NPerDefault     = 10;
  localparam int unsigned PMinDefault     = 8;
  localparam int unsigned PMaxDefault     = 9;
  localparam int unsigned LockWinsDefault = 2;
  localparam int unsigned TimeoutDefault  = 32;

  typedef enum logic [1:0] {
    SEEK,
    TRACK,
    LOCKED
  } mon_state_e;

endpackage

// File: rtl/div_period_meter.sv
// Rising-edge detector and period counter for the divided clock, all in the clk_in domain.
// Reports registered period_len/period_valid only when the caller enables reporting.
module div_period_meter
  import div_mon_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic            div_clk,
  input  logic            report,
  output logic            rise,
  output logic [CntW-1:0] cur_period,
  output logic            timeout,
  output logic [CntW-1:0] period_len,
  output logic            period_valid
);

  logic            div_q;
  logic [CntW-1:0] per_cnt;

  assign rise       = div_clk & ~div_q;
  assign cur_period = per_cnt;
  // Fires once: per_cnt walks past TIMEOUT on its way to saturation.
  assign timeout    = ~rise && (per_cnt == CntW'(TIMEOUT));

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      div_q        <= 1'b0;
      per_cnt      <= '0;
      period_len   <= '0;
      period_valid <= 1'b0;
    end else begin
      div_q        <= div_clk;
      period_valid <= rise & report;
      if (rise) begin
        per_cnt <= CntW'(1);
      end else if (per_cnt != '1) begin
        per_cnt <= per_cnt + CntW'(1);
      end
      if (rise && report) begin
        period_len <= per_cnt;
      end
    end
  end

endmodule

// File: rtl/div_ratio_monitor.sv
// Checks divided-clock periods and N-period window sums against the M/N ratio; reports lock/err.
// Optional DIV_MON_STICKY_ERR_EN adds err_sticky, set by any err pulse and cleared only by reset.
module div_ratio_monitor
  import div_mon_pkg::*;
#(
  parameter int unsigned M_N       = MnDefault,
  parameter int unsigned N_PER     = NPerDefault,
  parameter int unsigned P_MIN     = PMinDefault,
  parameter int unsigned P_MAX     = PMaxDefault,
  parameter int unsigned LOCK_WINS = LockWinsDefault,
  parameter int unsigned TIMEOUT   = TimeoutDefault
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic            div_clk,
  output logic [CntW-1:0] period_len,
  output logic            period_valid,
  output logic [CntW-1:0] win_sum,
  output logic            win_valid,
  output logic            locked,
  output logic            err
`ifdef DIV_MON_STICKY_ERR_EN
  ,
  output logic            err_sticky
`endif
);

  localparam logic [IdxW-1:0] IdxMax = IdxW'(N_PER);

  mon_state_e      state_q;
  logic [CntW-1:0] acc_q, acc_nxt;
  logic [IdxW-1:0] idx_q, idx_nxt;
  logic [CntW-1:0] good_q, good_nxt;
  logic            rise, timeout, close, range_bad, sum_bad, err_set;
  logic [CntW-1:0] cur_period;

  div_period_meter #(
    .TIMEOUT (TIMEOUT)
  ) u_meter (
    .clk_in       (clk_in),
    .rst          (rst),
    .div_clk      (div_clk),
    .report       (state_q != SEEK),
    .rise         (rise),
    .cur_period   (cur_period),
    .timeout      (timeout),
    .period_len   (period_len),
    .period_valid (period_valid)
  );

  always_comb begin
    acc_nxt   = acc_q + cur_period;
    idx_nxt   = idx_q + IdxW'(1);
    close     = (idx_nxt == IdxMax);
    range_bad = (cur_period < CntW'(P_MIN)) || (cur_period > CntW'(P_MAX));
    sum_bad   = (acc_nxt != CntW'(M_N));
    good_nxt  = (good_q == '1) ? good_q : good_q + CntW'(1);
    err_set   = 1'b0;
    if (state_q != SEEK) begin
      err_set = rise ? (range_bad || (close && sum_bad)) : timeout;
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q   <= SEEK;
      acc_q     <= '0;
      idx_q     <= '0;
      good_q    <= '0;
      win_sum   <= '0;
      win_valid <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
    end else begin
      win_valid <= 1'b0;
      err       <= err_set;
      if (err_set) begin
        locked <= 1'b0;
        good_q <= '0;
      end
      unique case (state_q)
        SEEK: begin
          if (rise) begin
            acc_q   <= '0;
            idx_q   <= '0;
            good_q  <= '0;
            state_q <= TRACK;
          end
        end
        TRACK, LOCKED: begin
          if (rise) begin
            // A window closing on a range error still publishes its partial sum.
            if (close) begin
              win_valid <= 1'b1;
              win_sum   <= acc_nxt;
            end
            if (err_set) begin
              acc_q   <= '0;
              idx_q   <= '0;
              state_q <= TRACK;
            end else if (close) begin
              acc_q  <= '0;
              idx_q  <= '0;
              good_q <= good_nxt;
              if (good_nxt >= CntW'(LOCK_WINS)) begin
                state_q <= LOCKED;
                locked  <= 1'b1;
              end
            end else begin
              acc_q <= acc_nxt;
              idx_q <= idx_nxt;
            end
          end else if (timeout) begin
            state_q <= SEEK;
          end
        end
        default: state_q <= SEEK;
      endcase
    end
  end

`ifdef DIV_MON_STICKY_ERR_EN
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      err_sticky <= 1'b0;
    end else if (err_set) begin
      err_sticky <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_div_ratio_monitor.sv
// Directed bench for div_ratio_monitor: period/window scoreboard plus lock, timeout and reset checks.
// Exercises err_sticky when built with DIV_MON_STICKY_ERR_EN.
module tb_div_ratio_monitor;

  logic       clk_in = 1'b0;
  logic       rst = 1'b0;
  logic       div_clk = 1'b0;
  logic [7:0] period_len, win_sum;
  logic       period_valid, win_valid, locked, err;
`ifdef DIV_MON_STICKY_ERR_EN
  logic       err_sticky;
`endif

  div_ratio_monitor dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .div_clk      (div_clk),
    .period_len   (period_len),
    .period_valid (period_valid),
    .win_sum      (win_sum),
    .win_valid    (win_valid),
    .locked       (locked),
    .err          (err)
`ifdef DIV_MON_STICKY_ERR_EN
    ,
    .err_sticky   (err_sticky)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int p;
    bit e;
  } pexp_t;

  pexp_t pq[$];
  int    wq[$];
  int    checks = 0;
  int    passes = 0;
  int    err_count = 0;
  int    exp_errs = 0;
  int    b_acc = 0;
  int    b_idx = 0;
  int    pat_i = 0;
  int    pat[10] = '{8, 8, 8, 9, 9, 9, 9, 9, 9, 9};
  pexp_t mon_e;
  int    mon_w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Scoreboard side: pop expectations whenever the DUT reports.
  always @(negedge clk_in) begin
    if (rst) begin
      if (err) err_count++;
      if (period_valid) begin
        if (pq.size() == 0) begin
          checks++;
          $error("FAIL period_unexpected: got len %0d expected none", period_len);
        end else begin
          mon_e = pq.pop_front();
          chk("period_len", 32'(period_len), mon_e.p);
          chk("err_with_period", 32'(err), 32'(mon_e.e));
        end
      end
      if (win_valid) begin
        if (wq.size() == 0) begin
          checks++;
          $error("FAIL win_unexpected: got sum %0d expected none", win_sum);
        end else begin
          mon_w = wq.pop_front();
          chk("win_sum", 32'(win_sum), mon_w);
        end
      end
    end
  end

  // First rise after SEEK: nothing is reported for it.
  task automatic start_edge();
    @(negedge clk_in) div_clk = 1'b1;
    @(negedge clk_in) div_clk = 1'b0;
    b_acc = 0;
    b_idx = 0;
  endtask

  // Gap of p cycles since the previous rise, then the next rise.
  task automatic per(input int p);
    bit rb, cl, e;
    repeat (p - 1) @(negedge clk_in);
    rb    = (p < 8) || (p > 9);
    b_acc = (b_acc + p) % 256;
    b_idx++;
    cl    = (b_idx == 10);
    e     = rb || (cl && b_acc != 87);
    pq.push_back('{p, e});
    if (cl) wq.push_back(b_acc);
    if (rb || cl) begin
      b_acc = 0;
      b_idx = 0;
    end
    if (e) exp_errs++;
    div_clk = 1'b1;
    @(negedge clk_in) div_clk = 1'b0;
  endtask

  task automatic ideal(input int n);
    for (int i = 0; i < n; i++) begin
      per(pat[pat_i % 10]);
      pat_i++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    repeat (3) @(negedge clk_in);
    chk("rst_period_len", 32'(period_len), 0);
    chk("rst_period_valid", 32'(period_valid), 0);
    chk("rst_win_sum", 32'(win_sum), 0);
    chk("rst_win_valid", 32'(win_valid), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err", 32'(err), 0);
    @(negedge clk_in) rst = 1'b1;

    // Ideal divider: lock after the second good window.
    start_edge();
    ideal(10);
    #1 chk("lock_after_w1", 32'(locked), 0);
    ideal(10);
    #1 chk("lock_after_w2", 32'(locked), 1);
    ideal(10);
    #1 chk("lock_after_w3", 32'(locked), 1);
    chk("ideal_no_err", err_count, 0);

    // Constant period 8: each window sums to 80 and errors.
    for (int i = 0; i < 20; i++) per(8);
    #1 chk("const8_locked", 32'(locked), 0);
    chk("const8_errs", err_count, exp_errs);

    // Relock, then out-of-range periods at both sides.
    ideal(20);
    #1 chk("relock", 32'(locked), 1);
    per(10);
    #1 chk("p10_unlock", 32'(locked), 0);
    per(7);
    ideal(10);
    #1 chk("after_err_w1", 32'(locked), 0);
    ideal(10);
    #1 chk("after_err_w2", 32'(locked), 1);
    chk("range_errs", err_count, exp_errs);

    // div_clk stuck low: timeout 32 cycles after the last rise.
    waited = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_in);
      if (err) begin
        waited = k;
        break;
      end
    end
    chk("timeout_latency", waited, 32);
    exp_errs++;
    #1 chk("timeout_locked", 32'(locked), 0);
    chk("timeout_errs", err_count, exp_errs);
    start_edge();
    ideal(10);
    #1 chk("post_to_w1", 32'(locked), 0);
    ideal(10);
    #1 chk("post_to_w2", 32'(locked), 1);

    // Asynchronous reset mid-window.
    ideal(5);
    #2 rst = 1'b0;
    #1;
    chk("arst_period_len", 32'(period_len), 0);
    chk("arst_win_sum", 32'(win_sum), 0);
    chk("arst_locked", 32'(locked), 0);
    chk("arst_err", 32'(err), 0);
    @(negedge clk_in) rst = 1'b1;
    start_edge();
    ideal(10);
    #1 chk("post_rst_w1", 32'(locked), 0);
    ideal(10);
    #1 chk("post_rst_w2", 32'(locked), 1);

`ifdef DIV_MON_STICKY_ERR_EN
    chk("sticky_clear", 32'(err_sticky), 0);
    per(10);
    #1 chk("sticky_set", 32'(err_sticky), 1);
    ideal(20);
    #1 chk("sticky_hold_locked", 32'(locked), 1);
    chk("sticky_hold", 32'(err_sticky), 1);
    #2 rst = 1'b0;
    #1 chk("sticky_rst", 32'(err_sticky), 0);
    @(negedge clk_in) rst = 1'b1;
`endif

    repeat (3) @(negedge clk_in);
    chk("final_errs", err_count, exp_errs);
    chk("periods_drained", pq.size(), 0);
    chk("windows_drained", wq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/div_ratio_monitor.md
Name: div_ratio_monitor

Overview:
Receive-side checker for the fractional M/N clock divider output. It samples the divided clock in the source clock domain and measures every divided period in clk_in cycles. It sums periods over N-period windows and compares each window against M. It then reports lock or error status to the clocking control/debug logic next to the divider.

Parameters:
M_N, 87, expected clk_in cycles per window (8-bit)
N_PER, 10, divided periods per window (5-bit)
P_MIN, 8, shortest legal period (floor of M/N)
P_MAX, 9, longest legal period (ceil of M/N)
LOCK_WINS, 2, consecutive good windows required for lock
TIMEOUT, 32, clk_in cycles without a rising edge before error (must exceed P_MAX)

Ports:
clk_in  input  1  source clock; all logic on rising edge
rst  input  1  asynchronous, active-low reset
div_clk  input  1  divided clock under test, synchronous to clk_in (no synchroniser)
period_len  output  8  last measured period in clk_in cycles
period_valid  output  1  one-cycle pulse, period_len updated
win_sum  output  8  last completed window sum
win_valid  output  1  one-cycle pulse, win_sum updated
locked  output  1  ratio confirmed
err  output  1  one-cycle error pulse

Behaviour:
- Reset values: period_len=0, period_valid=0, win_sum=0, win_valid=0, locked=0, err=0, state=SEEK, all counters 0, div_q=0.
- Edge detect: div_q registers div_clk. rise = div_clk & ~div_q.
- per_cnt (8-bit): loads 1 on rise, otherwise increments, saturating at 255.
- Period latency: when rise occurs, the period is per_cnt, the clk_in-cycle distance between successive rises. period_len and period_valid are registered and appear one cycle after the rise.
- States:
  - SEEK: wait for the first rise. On rise, clear per_cnt to 1, clear accumulator and period index, clear good-window count, go to TRACK. No period is reported for this first edge.
  - TRACK: on each rise, report the period, add it to the 8-bit accumulator (wrap allowed), and increment the period index.
  - Window close: when the index reaches N_PER, win_sum = accumulator including the current period, win_valid pulses, and the accumulator and index clear.
  - Good window: win_sum == M_N and all periods within [P_MIN, P_MAX]. Increment the good count, saturating. When the count reaches LOCK_WINS, go to LOCKED and set locked=1 in that same registered update.
  - LOCKED: same measurement as TRACK. locked stays 1 while windows remain good.
- Errors, any state except SEEK:
  - A period outside [P_MIN, P_MAX] gives err pulse in the same cycle as period_valid. The window is abandoned and the accumulator and index clear.
  - A window sum != M_N gives err with win_valid.
  - A timeout (per_cnt reaches TIMEOUT with no rise) gives err.
  - On any error: locked=0, good count=0. Range and sum errors go to TRACK; timeout goes to SEEK.
- Simultaneous events: a range error and window close in the same rise report one err pulse. win_valid still pulses with the partial-sum value.
- Window alignment is arbitrary. Any N_PER consecutive periods of a correct divider sum to M_N.
- Reset mid-operation aborts everything immediately. Outputs take their reset values asynchronously.

Optional Feature:
DIV_MON_STICKY_ERR_EN: when defined, adds output err_sticky (1 bit). It is set on any err pulse and cleared only by rst. When undefined, the port is absent and only the err pulse exists.

Decomposition:
- Package div_mon_pkg: state enum {SEEK, TRACK, LOCKED}, 8-bit count width constant, default M_N/N_PER/P_MIN/P_MAX values shared with the divider.
- One sub-module, div_period_meter: edge detect, per_cnt, period_len/period_valid and timeout flag. The top holds the FSM, window accumulator and lock logic.

Test Plan:
- Ideal divider pattern (periods 8,8,8,9,9,9,9,9,9,9 repeating) -> period_len sequence matches; win_sum=87 each window; locked=1 after window 2; err never asserted.
- Constant period 8 -> win_sum=80 each window; err pulses with win_valid; locked stays 0.
- One period of 10 injected after lock -> err with that period_valid; locked=0; next full window reports 87 and relock follows after 2 good windows.
- div_clk held low after lock -> err 32 cycles after the last rise; state SEEK; no period_valid until two new rises.
- rst asserted mid-window then released -> all outputs 0 immediately; first valid period only after two rises; lock needs 2 fresh windows.
- With DIV_MON_STICKY_ERR_EN, a single range error -> err_sticky=1 and it holds through later good windows until rst.
